ins_dispatcher: RTL and testbench
=================================

INS_DISPATCHER -- requirements
Module: ins_dispatcher

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning instruction FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning issued/completed counter width.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning max cycles awaiting completion before error.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 ins_valid_i  input  1  host offers instruction.
REQ-007 ins_data_i  input  32  host instruction word (bit 31 = execute flag).
REQ-008 ins_ready_o  output  1  FIFO accepts the word this cycle.
REQ-009 flush_i  input  1  discard all queued (not in-flight) instructions.
REQ-010 ctrl_en_o  output  1  one-cycle issue strobe to the instruction controller.
REQ-011 ctrl_ins_o  output  32  instruction being issued; held until next issue.
REQ-012 ctrl_busy_i  input  1  controller busy (not in IDLE).
REQ-013 ctrl_valid_i  input  1  controller completion pulse.
REQ-014 fifo_count_o  output  $clog2(DEPTH)+1  queued entries.
REQ-015 issued_cnt_o / done_cnt_o  output  CNT_W each  issues / completions since reset.
REQ-016 idle_o  output  1  FIFO empty and nothing in flight.
REQ-017 err_o  output  1  sticky timeout flag.

Function
REQ-018 Push SHALL occur when ins_valid_i && ins_ready_o; ins_ready_o = !full && !flush_i, derived from registered count (no same-cycle pop bypass when full).
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT.
REQ-020 IDLE -> ISSUE when FIFO non-empty && !ctrl_busy_i && !flush_i; head is popped and registered into ctrl_ins_o on that edge.
REQ-021 In ISSUE ctrl_en_o SHALL be 1 for exactly one cycle; ISSUE -> WAIT unconditionally; issued_cnt_o increments (wraps at 2^CNT_W).
REQ-022 In WAIT, ctrl_valid_i SHALL return FSM to IDLE and increment done_cnt_o (wraps).
REQ-023 A new issue SHALL be possible the cycle after ctrl_valid_i if ctrl_busy_i is low (back-to-back throughput: issue, then completion, then re-issue).
REQ-024 Non-execute words (bit 31 = 0) SHALL be issued identically; controller completes them in 2 cycles.
REQ-025 WAIT cycle counter SHALL reset on entry; reaching TIMEOUT without ctrl_valid_i sets err_o, returns to IDLE, done_cnt_o unchanged.
REQ-026 ctrl_valid_i outside WAIT SHALL be ignored (no counter change).
REQ-027 flush_i SHALL empty FIFO next edge, drop any same-cycle push, and not affect an instruction in ISSUE/WAIT.
REQ-028 Simultaneous push and pop (not full) SHALL leave fifo_count_o unchanged; pointers wrap modulo DEPTH.
REQ-029 idle_o = (state==IDLE) && count==0, combinational from registers.

Reset
REQ-030 On rst_ni low (any cycle, mid-transfer included) SHALL immediately force: state IDLE, FIFO empty, ctrl_en_o 0, ctrl_ins_o 0, counters 0, err_o 0, timeout counter 0; ins_ready_o 0 while asserted.
REQ-031 Release SHALL be synchronous-safe: first push accepted no earlier than first edge after deassertion.

Structure
REQ-032 Shared package SHALL hold FSM state encoding, instruction field positions (execute bit 31, address/mode fields) shared with the controller.
REQ-033 FIFO SHALL be a sub-module sync_fifo (DEPTH, width 32, count output); FSM, timeout and counters in the top.

Verification
REQ-034 Push 3 words 0x80000001..3 with modelled 3-cycle-latency controller -> 3 ctrl_en_o pulses, ctrl_ins_o in order, issued=done=3, idle_o=1.
REQ-035 Push 9 words with controller stalled busy -> 9th refused (ins_ready_o=0), fifo_count_o=8.
REQ-036 Controller never asserts ctrl_valid_i -> err_o=1 exactly 64 cycles after WAIT entry, FSM IDLE, done=0.
REQ-037 flush_i with 4 queued and one in WAIT -> count 0 next cycle, in-flight completes, done=1.
REQ-038 Assert rst_ni low during WAIT -> all outputs zero without clock edge; normal operation after release.
REQ-039 Word 0x00000005 (execute=0) -> issued, completion accepted, done=1.

Source files
------------

// File: rtl/ins_dispatcher_pkg.sv
// Shared definitions for the instruction dispatcher and the instruction
// controller it feeds: FSM encoding and instruction word field layout.
package ins_dispatcher_pkg;

    // Instruction word layout shared with the controller.
    localparam int INS_W        = 32;
    localparam int INS_EXEC_BIT = 31;
    localparam int INS_MODE_LSB = 28;
    localparam int INS_MODE_W   = 3;
    localparam int INS_ADDR_LSB = 0;
    localparam int INS_ADDR_W   = 28;

    // Dispatcher FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } disp_state_e;

    // True when the word asks the controller to execute (bit 31 set).
    function automatic logic ins_is_exec(input logic [INS_W-1:0] ins);
        return ins[INS_EXEC_BIT];
    endfunction

endpackage

// File: rtl/ins_dispatcher_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush. Storage has
// no reset so it can map onto RAM; only pointers and count are reset.
module sync_fifo
    import ins_dispatcher_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = INS_W
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow; flush discards any same-cycle push.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    assign full_o  = (count_reg == CW'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign count_o = count_reg;
    assign data_o  = mem[rd_ptr_reg];

    // Entry storage, written at the tail pointer.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ins_dispatcher.sv
// Instruction dispatcher: queues host words and hands them one at a time to
// the instruction controller, waiting for completion (or a timeout) between
// issues. Keeps issue/completion counters and a sticky timeout flag.
module ins_dispatcher
    import ins_dispatcher_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     ins_valid_i,
    input  logic [INS_W-1:0]         ins_data_i,
    output logic                     ins_ready_o,
    input  logic                     flush_i,
    output logic                     ctrl_en_o,
    output logic [INS_W-1:0]         ctrl_ins_o,
    input  logic                     ctrl_busy_i,
    input  logic                     ctrl_valid_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic [CNT_W-1:0]         issued_cnt_o,
    output logic [CNT_W-1:0]         done_cnt_o,
    output logic                     idle_o,
    output logic                     err_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    disp_state_e      state_reg;
    disp_state_e      state_next;
    logic [TMR_W-1:0] tmr_reg;
    logic [INS_W-1:0] ctrl_ins_reg;
    logic [CNT_W-1:0] issued_reg;
    logic [CNT_W-1:0] done_reg;
    logic             err_reg;
    logic             pop;
    logic             push;
    logic             timeout_hit;
    logic             fifo_full;
    logic             fifo_empty;
    logic [INS_W-1:0] fifo_head;

    // Ready is held low during reset and never bypasses a same-cycle pop when full.
    assign ins_ready_o = rst_ni && !fifo_full && !flush_i;
    assign push        = ins_valid_i && ins_ready_o;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INS_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (ins_data_i),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .count_o (fifo_count_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state logic: pop on leaving IDLE; WAIT ends on completion or timeout.
    always_comb begin
        state_next  = state_reg;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty && !ctrl_busy_i && !flush_i) begin
                    pop        = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctrl_valid_i) begin
                    state_next = ST_IDLE;
                end else if (tmr_reg == TMR_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and the instruction latched on each issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= ST_IDLE;
            ctrl_ins_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (pop) begin
                ctrl_ins_reg <= fifo_head;
            end
        end
    end

    // WAIT-cycle counter: zero outside WAIT, so it restarts on every entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmr_reg <= '0;
        end else if (state_reg == ST_WAIT) begin
            tmr_reg <= tmr_reg + 1'b1;
        end else begin
            tmr_reg <= '0;
        end
    end

    // Issue/completion counters (wrapping) and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_reg <= '0;
            done_reg   <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (state_reg == ST_ISSUE) begin
                issued_reg <= issued_reg + 1'b1;
            end
            if (state_reg == ST_WAIT && ctrl_valid_i) begin
                done_reg <= done_reg + 1'b1;
            end
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign ctrl_en_o    = (state_reg == ST_ISSUE);
    assign ctrl_ins_o   = ctrl_ins_reg;
    assign issued_cnt_o = issued_reg;
    assign done_cnt_o   = done_reg;
    assign err_o        = err_reg;
    assign idle_o       = (state_reg == ST_IDLE) && (fifo_count_o == '0);

endmodule

// File: tb/tb_ins_dispatcher.sv
// Bench for ins_dispatcher: a transaction-level model (word queue, in-flight
// flag, counters) plus a small controller model, driven by directed scenarios
// and a randomized phase.
module tb_ins_dispatcher;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic              clk_i;
    logic              rst_ni;
    logic              ins_valid_i;
    logic [31:0]       ins_data_i;
    logic              ins_ready_o;
    logic              flush_i;
    logic              ctrl_en_o;
    logic [31:0]       ctrl_ins_o;
    logic              ctrl_busy_i;
    logic              ctrl_valid_i;
    logic [CW-1:0]     fifo_count_o;
    logic [CNT_W-1:0]  issued_cnt_o;
    logic [CNT_W-1:0]  done_cnt_o;
    logic              idle_o;
    logic              err_o;

    ins_dispatcher #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ins_valid_i  (ins_valid_i),
        .ins_data_i   (ins_data_i),
        .ins_ready_o  (ins_ready_o),
        .flush_i      (flush_i),
        .ctrl_en_o    (ctrl_en_o),
        .ctrl_ins_o   (ctrl_ins_o),
        .ctrl_busy_i  (ctrl_busy_i),
        .ctrl_valid_i (ctrl_valid_i),
        .fifo_count_o (fifo_count_o),
        .issued_cnt_o (issued_cnt_o),
        .done_cnt_o   (done_cnt_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic [31:0]      q[$];
    bit               in_flight;
    bit               issuing;
    bit               err_m;
    logic [31:0]      exp_ins;
    int               wait_age;
    logic [CNT_W-1:0] iss_m;
    logic [CNT_W-1:0] done_m;

    // Controller model knobs and state.
    int unsigned ctl_lat   = 3;
    bit          ctl_mute  = 0;
    bit          ctl_stall = 0;
    bit          stray_en  = 0;
    int          ctl_cnt   = 0;

    // Observation bookkeeping.
    int cyc         = 0;
    int en_seen     = 0;
    int last_en_cyc = 0;
    int err_cyc     = -1;
    bit err_seen    = 0;
    bit last_ready  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        in_flight = 0;
        issuing   = 0;
        err_m     = 0;
        exp_ins   = '0;
        wait_age  = 0;
        iss_m     = '0;
        done_m    = '0;
        ctl_cnt   = 0;
        err_seen  = 0;
        err_cyc   = -1;
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model over the next edge.
    task automatic step(input bit v, input logic [31:0] d, input bit f);
        bit busy;
        bit cvalid;
        bit ready_m;
        bit pop;
        bit in_wait;
        @(negedge clk_i);
        cyc++;
        chk("ctrl_en",    32'(ctrl_en_o),    32'(issuing));
        chk("ctrl_ins",   ctrl_ins_o,        exp_ins);
        chk("fifo_count", 32'(fifo_count_o), 32'(q.size()));
        chk("issued",     32'(issued_cnt_o), 32'(iss_m));
        chk("done",       32'(done_cnt_o),   32'(done_m));
        chk("idle",       32'(idle_o),       32'(!in_flight && q.size() == 0));
        chk("err",        32'(err_o),        32'(err_m));
        if (ctrl_en_o) begin
            en_seen++;
            last_en_cyc = cyc;
        end
        if (err_o && !err_seen) begin
            err_seen = 1;
            err_cyc  = cyc;
        end

        // Controller: completion pulse after its latency; non-execute words take 2 cycles.
        in_wait = in_flight && !issuing;
        cvalid  = 0;
        if (ctl_cnt > 0) begin
            ctl_cnt--;
            if (ctl_cnt == 0) cvalid = 1;
        end
        if (issuing && !ctl_mute) ctl_cnt = exp_ins[31] ? int'(ctl_lat) : 2;
        if (stray_en && !in_wait && ($urandom % 8 == 0)) cvalid = 1;
        busy = ctl_stall || (ctl_cnt > 0);

        ins_valid_i  = v;
        ins_data_i   = d;
        flush_i      = f;
        ctrl_busy_i  = busy;
        ctrl_valid_i = cvalid;
        #1;
        ready_m    = (q.size() < DEPTH) && !f;
        last_ready = ins_ready_o;
        chk("ready", 32'(ins_ready_o), 32'(ready_m));

        // Effect of the coming edge.
        pop = !in_flight && (q.size() > 0) && !busy && !f;
        if (issuing) begin
            iss_m++;
        end else if (in_flight) begin
            if (cvalid) begin
                done_m++;
                in_flight = 0;
            end else begin
                wait_age++;
                if (wait_age == TIMEOUT) begin
                    err_m     = 1;
                    in_flight = 0;
                end
            end
        end
        issuing = 0;
        if (f) begin
            q.delete();
        end else if (pop) begin
            exp_ins   = q.pop_front();
            issuing   = 1;
            in_flight = 1;
            wait_age  = 0;
        end
        if (v && ready_m) q.push_back(d);
    endtask

    // Asynchronous reset asserted away from any edge; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(negedge clk_i);
        #2;
        rst_ni       = 1'b0;
        ins_valid_i  = 1'b0;
        ins_data_i   = '0;
        flush_i      = 1'b0;
        ctrl_busy_i  = 1'b0;
        ctrl_valid_i = 1'b0;
        #1;
        chk({tag, "_en"},     32'(ctrl_en_o),    32'd0);
        chk({tag, "_ins"},    ctrl_ins_o,        32'd0);
        chk({tag, "_count"},  32'(fifo_count_o), 32'd0);
        chk({tag, "_issued"}, 32'(issued_cnt_o), 32'd0);
        chk({tag, "_done"},   32'(done_cnt_o),   32'd0);
        chk({tag, "_err"},    32'(err_o),        32'd0);
        chk({tag, "_ready"},  32'(ins_ready_o),  32'd0);
        model_reset();
        repeat (2) begin
            @(negedge clk_i);
            chk({tag, "_ready_hold"}, 32'(ins_ready_o), 32'd0);
        end
        rst_ni = 1'b1;
    endtask

    initial begin
        int en0;
        rst_ni       = 1'b1;
        ins_valid_i  = 1'b0;
        ins_data_i   = '0;
        flush_i      = 1'b0;
        ctrl_busy_i  = 1'b0;
        ctrl_valid_i = 1'b0;
        model_reset();

        do_reset("rst0");

        // Three execute words through a 3-cycle controller.
        ctl_lat = 3;
        en0 = en_seen;
        for (int i = 1; i <= 3; i++) step(1'b1, 32'h8000_0000 | 32'(i), 1'b0);
        repeat (30) step(1'b0, '0, 1'b0);
        chk("s1_pulses", 32'(en_seen - en0),  32'd3);
        chk("s1_issued", 32'(issued_cnt_o),   32'd3);
        chk("s1_done",   32'(done_cnt_o),     32'd3);
        chk("s1_idle",   32'(idle_o),         32'd1);

        // Non-execute word is issued and completed like any other.
        step(1'b1, 32'h0000_0005, 1'b0);
        repeat (15) step(1'b0, '0, 1'b0);
        chk("s6_ins",  ctrl_ins_o,         32'h0000_0005);
        chk("s6_done", 32'(done_cnt_o),    32'd4);

        // Controller never completes: timeout after exactly TIMEOUT WAIT cycles.
        do_reset("rst1");
        ctl_mute = 1;
        step(1'b1, 32'h8000_0010, 1'b0);
        repeat (TIMEOUT + 10) step(1'b0, '0, 1'b0);
        chk("s3_err",     32'(err_o),                 32'd1);
        chk("s3_latency", 32'(err_cyc - last_en_cyc), 32'(TIMEOUT + 1));
        chk("s3_idle",    32'(idle_o),                32'd1);
        chk("s3_done",    32'(done_cnt_o),            32'd0);
        ctl_mute = 0;

        // Reset in the middle of a WAIT with words still queued.
        ctl_lat = 20;
        step(1'b1, 32'h8000_00ab, 1'b0);
        step(1'b1, 32'h8000_00cd, 1'b0);
        step(1'b1, 32'h0000_00ef, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0);
        do_reset("rst2");

        // Stalled controller: ninth word refused, FIFO holds DEPTH entries.
        ctl_stall = 1;
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 32'h4000_0000 + 32'(i), 1'b0);
        chk("s2_ready9", 32'(last_ready), 32'd0);
        step(1'b0, '0, 1'b0);
        chk("s2_count", 32'(fifo_count_o), 32'(DEPTH));
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("s2_flushed", 32'(fifo_count_o), 32'd0);

        // Flush with four queued and one in flight: in-flight still completes.
        ctl_stall = 0;
        ctl_lat   = 12;
        for (int i = 0; i < 5; i++) step(1'b1, 32'h8000_0100 + 32'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("s5_count0", 32'(fifo_count_o), 32'd0);
        repeat (20) step(1'b0, '0, 1'b0);
        chk("s5_done", 32'(done_cnt_o), 32'd1);
        chk("s5_idle", 32'(idle_o),     32'd1);

        // Randomized traffic with stalls, stray completions and occasional flushes.
        stray_en = 1;
        repeat (500) begin
            ctl_lat   = $urandom_range(1, 4);
            ctl_stall = ($urandom % 8 == 0);
            step(1'($urandom_range(0, 1)), $urandom, ($urandom % 16 == 0));
        end
        stray_en  = 0;
        ctl_stall = 0;
        repeat (40) step(1'b0, '0, 1'b0);
        chk("rand_idle", 32'(idle_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
